// File: rtl/train_seq_if.sv
// Control/status bundle between the training sequencer and its controller.
interface train_seq_if #(
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned EWIDTH = 16
);
  logic              start;
  logic              abort;
  logic              nn_done;
  logic [AWIDTH-1:0] addr;
  logic              rd_en;
  logic              nn_start;
  logic [EWIDTH-1:0] epoch;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, nn_done,
    input  addr, rd_en, nn_start, epoch, busy, done
  );

  modport slave (
    input  start, abort, nn_done,
    output addr, rd_en, nn_start, epoch, busy, done
  );
endinterface

// File: rtl/train_seq.sv
// Training-sample sequencer: walks NSAMPLE k2 addresses per epoch for MAX_EPOCH
// epochs, launching the network once per sample and waiting for its completion.
module train_seq #(
  parameter int unsigned AWIDTH    = 4,
  parameter int unsigned NSAMPLE   = 4,
  parameter int unsigned EWIDTH    = 16,
  parameter int unsigned MAX_EPOCH = 1000
) (
  input  logic        clk,
  input  logic        rst,
  train_seq_if.slave  bus
);

  // A run of zero epochs is meaningless; run one instead.
  localparam int unsigned EPOCHS = (MAX_EPOCH == 0) ? 1 : MAX_EPOCH;
  localparam logic [AWIDTH-1:0] LAST_ADDR  = AWIDTH'(NSAMPLE - 1);
  localparam logic [EWIDTH-1:0] LAST_EPOCH = EWIDTH'(EPOCHS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LAUNCH  = 3'd2;
  localparam logic [2:0] S_WAIT_NN = 3'd3;
  localparam logic [2:0] S_NEXT    = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [EWIDTH-1:0] epoch_q, epoch_d, epoch_inc;
  logic              rd_en_q, rd_en_d;
  logic              nn_start_q, nn_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state, counter update and output decode of the next state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    epoch_d    = epoch_q;
    epoch_inc  = epoch_q + EWIDTH'(1);
    rd_en_d    = 1'b0;
    nn_start_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          addr_d  = '0;
          epoch_d = '0;
        end
      end
      S_FETCH:   state_d = S_LAUNCH;
      S_LAUNCH:  state_d = S_WAIT_NN;
      S_WAIT_NN: begin
        if (bus.nn_done) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          epoch_d = epoch_inc;
          state_d = (epoch_inc == LAST_EPOCH) ? S_FINISH : S_FETCH;
        end else begin
          addr_d  = addr_q + AWIDTH'(1);
          state_d = S_FETCH;
        end
      end
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Abort overrides every transition out of a busy state and freezes the counters.
    if ((state_q != S_IDLE) && bus.abort) begin
      state_d = S_IDLE;
      addr_d  = addr_q;
      epoch_d = epoch_q;
    end

    // rd_en spans FETCH..WAIT_NN so the memory output stays driven while consumed.
    rd_en_d    = (state_d == S_FETCH) || (state_d == S_LAUNCH) || (state_d == S_WAIT_NN);
    nn_start_d = (state_d == S_LAUNCH);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FINISH);
  end

  // State, counters and registered state-decoded outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      epoch_q    <= '0;
      rd_en_q    <= 1'b0;
      nn_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      epoch_q    <= epoch_d;
      rd_en_q    <= rd_en_d;
      nn_start_q <= nn_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.addr     = addr_q;
  assign bus.epoch    = epoch_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.nn_start = nn_start_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
